// File: rtl/l1d_pkg.sv
// Shared types, default geometry and derived-width helpers for the L1-D data array.
package l1d_pkg;
    typedef enum logic [1:0] {INIT, IDLE, REFILL} l1d_arr_state_e;

    localparam int DEF_SETS      = 64;
    localparam int DEF_WAYS      = 2;
    localparam int DEF_LINE_BITS = 512;
    localparam int DEF_WORD_BITS = 32;
    localparam int DEF_L2_BITS   = 128;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int off_w(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int beats(input int line_bits, input int l2_bits);
        return line_bits / l2_bits;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/l1d_refill_ctrl.sv
// Array sequencer: power-on zeroing sweep, refill beat tracking, stall/refill_done.
module l1d_refill_ctrl
    import l1d_pkg::*;
#(
    parameter int SETS   = DEF_SETS,
    parameter int BEATS  = 4,
    parameter int IDX_W  = 6,
    parameter int WAY_W  = 1,
    parameter int BEAT_W = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_refill_start,
    input  logic [IDX_W-1:0]  i_refill_index,
    input  logic [WAY_W-1:0]  i_refill_way,
    input  logic              i_l2_valid,
    output logic              o_stall,
    output logic              o_refill_done,
    output logic              o_init_we,
    output logic              o_refill_we,
    output logic [IDX_W-1:0]  o_wr_index,
    output logic [WAY_W-1:0]  o_wr_way,
    output logic [BEAT_W-1:0] o_wr_lane
);
    l1d_arr_state_e    r_state, w_next;
    logic [IDX_W-1:0]  r_sweep, r_idx;
    logic [WAY_W-1:0]  r_way;
    logic [BEAT_W-1:0] r_beat;
    logic              r_stall, r_done;
    logic              w_start, w_done;

    always_comb begin
        w_next      = r_state;
        o_init_we   = 1'b0;
        o_refill_we = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            INIT: begin
                o_init_we = 1'b1;
                if (r_sweep == IDX_W'(SETS - 1)) w_next = IDLE;
            end
            IDLE: begin
                if (i_refill_start) begin
                    w_start = 1'b1;
                    w_next  = REFILL;
                end
            end
            REFILL: begin
                if (i_l2_valid) begin
                    o_refill_we = 1'b1;
                    if (r_beat == BEAT_W'(BEATS - 1)) begin
                        w_done = 1'b1;
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= INIT;
            r_sweep <= '0;
            r_idx   <= '0;
            r_way   <= '0;
            r_beat  <= '0;
            r_stall <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_stall <= (w_next != IDLE);
            r_done  <= w_done;
            if (o_init_we) r_sweep <= r_sweep + IDX_W'(1);
            if (w_start) begin
                r_idx  <= i_refill_index;
                r_way  <= i_refill_way;
                r_beat <= '0;
            end else if (o_refill_we) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
        end
    end

    // During INIT the sweep counter addresses the array; otherwise the latched refill target does.
    assign o_wr_index    = (r_state == INIT) ? r_sweep : r_idx;
    assign o_wr_way      = r_way;
    assign o_wr_lane     = r_beat;
    assign o_stall       = r_stall;
    assign o_refill_done = r_done;
endmodule

// File: rtl/l1d_data_array_pm.sv
// L1-D data array: byte-enabled core word access, multi-beat L2 refill, zeroed after reset.
module l1d_data_array_pm
    import l1d_pkg::*;
#(
    parameter int SETS      = DEF_SETS,
    parameter int WAYS      = DEF_WAYS,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int WORD_BITS = DEF_WORD_BITS,
    parameter int L2_BITS   = DEF_L2_BITS,
    localparam int IDX_W    = idx_w(SETS),
    localparam int WAY_W    = way_w(WAYS),
    localparam int OFF_W    = off_w(LINE_BITS),
    localparam int BE_W     = WORD_BITS / 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [IDX_W-1:0]     req_index,
    input  logic [WAY_W-1:0]     req_way,
    input  logic [OFF_W-1:0]     req_offset,
    input  logic [WORD_BITS-1:0] req_wdata,
    input  logic [BE_W-1:0]      req_be,
    output logic [WORD_BITS-1:0] rdata,
    output logic [LINE_BITS-1:0] line_rdata,
    output logic                 rvalid,
    input  logic                 refill_start,
    input  logic [IDX_W-1:0]     refill_index,
    input  logic [WAY_W-1:0]     refill_way,
    input  logic                 l2_valid,
    input  logic [L2_BITS-1:0]   l2_data,
    output logic                 refill_done,
    output logic                 stall
);
    localparam int BEATS  = beats(LINE_BITS, L2_BITS);
    localparam int BEAT_W = cnt_w(BEATS);
    localparam int BSEL_W = $clog2(BE_W);
    localparam int WSEL_W = OFF_W - BSEL_W;
    localparam int LINES  = SETS * WAYS;
    localparam int ADDR_W = $clog2(LINES);

    logic [LINE_BITS-1:0] r_mem [LINES];
    logic [WORD_BITS-1:0] r_rdata;
    logic [LINE_BITS-1:0] r_line;
    logic                 r_rvalid;

    logic                 w_init_we, w_refill_we, w_stall, w_acc, w_rd;
    logic [IDX_W-1:0]     w_wr_index;
    logic [WAY_W-1:0]     w_wr_way;
    logic [BEAT_W-1:0]    w_wr_lane;
    logic [WSEL_W-1:0]    w_wsel;
    logic [ADDR_W-1:0]    w_req_addr, w_wr_addr;
    logic [LINE_BITS-1:0] w_line;
    logic                 w_unused_ok;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [IDX_W-1:0] idx,
                                                    input logic [WAY_W-1:0] way);
        if (WAYS == 1) return ADDR_W'(idx);
        return ADDR_W'({idx, way});
    endfunction

    l1d_refill_ctrl #(
        .SETS(SETS), .BEATS(BEATS), .IDX_W(IDX_W), .WAY_W(WAY_W), .BEAT_W(BEAT_W)
    ) u_ctrl (
        .clk            (clk),
        .nrst           (nrst),
        .i_refill_start (refill_start),
        .i_refill_index (refill_index),
        .i_refill_way   (refill_way),
        .i_l2_valid     (l2_valid),
        .o_stall        (w_stall),
        .o_refill_done  (refill_done),
        .o_init_we      (w_init_we),
        .o_refill_we    (w_refill_we),
        .o_wr_index     (w_wr_index),
        .o_wr_way       (w_wr_way),
        .o_wr_lane      (w_wr_lane)
    );

    assign w_acc       = req_valid & ~w_stall;
    assign w_rd        = w_acc & ~req_we;
    // Low offset bits select a byte inside the word; accesses are word-aligned so they drop out.
    assign w_wsel      = req_offset[OFF_W-1:BSEL_W];
    assign w_unused_ok = ^req_offset;
    assign w_req_addr  = line_addr(req_index, req_way);
    assign w_wr_addr   = line_addr(w_wr_index, w_wr_way);
    assign w_line      = r_mem[w_req_addr];

    // Storage has no reset; the INIT sweep clears it. Core writes only occur in IDLE, so
    // they never collide with sweep or refill writes.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            for (int w = 0; w < WAYS; w++)
                r_mem[line_addr(w_wr_index, WAY_W'(w))] <= '0;
        end
        if (w_refill_we)
            r_mem[w_wr_addr][w_wr_lane*L2_BITS +: L2_BITS] <= l2_data;
        if (w_acc && req_we) begin
            for (int b = 0; b < BE_W; b++)
                if (req_be[b])
                    r_mem[w_req_addr][w_wsel*WORD_BITS + b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_line   <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_line[w_wsel*WORD_BITS +: WORD_BITS];
                r_line  <= w_line;
            end
        end
    end

    assign rdata      = r_rdata;
    assign line_rdata = r_line;
    assign rvalid     = r_rvalid;
    assign stall      = w_stall;
endmodule

// File: tb/tb_l1d_data_array_pm.sv
// Directed bench: default-geometry array plus a 16x1x256 single-beat instance.
module tb_l1d_data_array_pm;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic         a_req_valid, a_req_we, a_req_way, a_refill_start, a_refill_way, a_l2_valid;
    logic [5:0]   a_req_index, a_req_offset, a_refill_index;
    logic [31:0]  a_req_wdata, a_rdata;
    logic [3:0]   a_req_be;
    logic [511:0] a_line;
    logic [127:0] a_l2_data;
    logic         a_rvalid, a_done, a_stall;

    logic         b_req_valid, b_req_we, b_req_way, b_refill_start, b_refill_way, b_l2_valid;
    logic [3:0]   b_req_index, b_refill_index;
    logic [4:0]   b_req_offset;
    logic [31:0]  b_req_wdata, b_rdata;
    logic [3:0]   b_req_be;
    logic [255:0] b_line, b_l2_data;
    logic         b_rvalid, b_done, b_stall;

    l1d_data_array_pm dut_a (
        .clk(clk), .nrst(nrst),
        .req_valid(a_req_valid), .req_we(a_req_we), .req_index(a_req_index), .req_way(a_req_way),
        .req_offset(a_req_offset), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rdata(a_rdata), .line_rdata(a_line), .rvalid(a_rvalid),
        .refill_start(a_refill_start), .refill_index(a_refill_index), .refill_way(a_refill_way),
        .l2_valid(a_l2_valid), .l2_data(a_l2_data), .refill_done(a_done), .stall(a_stall)
    );

    l1d_data_array_pm #(.SETS(16), .WAYS(1), .LINE_BITS(256), .WORD_BITS(32), .L2_BITS(256)) dut_b (
        .clk(clk), .nrst(nrst),
        .req_valid(b_req_valid), .req_we(b_req_we), .req_index(b_req_index), .req_way(b_req_way),
        .req_offset(b_req_offset), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rdata(b_rdata), .line_rdata(b_line), .rvalid(b_rvalid),
        .refill_start(b_refill_start), .refill_index(b_refill_index), .refill_way(b_refill_way),
        .l2_valid(b_l2_valid), .l2_data(b_l2_data), .refill_done(b_done), .stall(b_stall)
    );

    typedef struct {
        logic        we;
        logic [5:0]  idx;
        logic        way;
        logic [5:0]  off;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic a_req(input logic we, input logic [5:0] idx, input logic way,
                         input logic [5:0] off, input logic [31:0] wd, input logic [3:0] be);
        a_req_valid = 1'b1; a_req_we = we; a_req_index = idx; a_req_way = way;
        a_req_offset = off; a_req_wdata = wd; a_req_be = be;
    endtask

    task automatic a_read_line(input string name, input logic [5:0] idx, input logic way,
                               input logic [5:0] off, input logic [511:0] exp_line);
        a_req(1'b0, idx, way, off, 32'h0, 4'h0);
        tick;
        a_req_valid = 1'b0;
        chk({name, "_rvalid"}, 512'(a_rvalid), 512'(1));
        chk({name, "_line"}, a_line, exp_line);
    endtask

    task automatic init_wait(input string tag);
        int ca, cb;
        bit da, db;
        ca = 0; cb = 0; da = 0; db = 0;
        for (int i = 1; i <= 200 && !(da && db); i++) begin
            tick;
            if (!da && !a_stall) begin da = 1; ca = i; end
            if (!db && !b_stall) begin db = 1; cb = i; end
        end
        chk({tag, "_init_cycles_a"}, 512'(ca), 512'(64));
        chk({tag, "_init_cycles_b"}, 512'(cb), 512'(16));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[13];
        logic [511:0] el;
        logic [7:0]   bv;
        vt[0]  = '{1'b1, 6'd5,  1'b0, 6'h08, 32'hDEADBEEF, 4'b0101, 32'h0};
        vt[1]  = '{1'b0, 6'd5,  1'b0, 6'h08, 32'h0,        4'h0,    32'h00AD00EF};
        vt[2]  = '{1'b0, 6'd5,  1'b0, 6'h04, 32'h0,        4'h0,    32'h0};
        vt[3]  = '{1'b0, 6'd5,  1'b0, 6'h0C, 32'h0,        4'h0,    32'h0};
        vt[4]  = '{1'b0, 6'd5,  1'b1, 6'h08, 32'h0,        4'h0,    32'h0};
        vt[5]  = '{1'b0, 6'd4,  1'b0, 6'h08, 32'h0,        4'h0,    32'h0};
        vt[6]  = '{1'b1, 6'd5,  1'b0, 6'h0B, 32'h12345678, 4'hF,    32'h0};
        vt[7]  = '{1'b0, 6'd5,  1'b0, 6'h08, 32'h0,        4'h0,    32'h12345678};
        vt[8]  = '{1'b1, 6'd5,  1'b0, 6'h08, 32'hAABBCCDD, 4'b1000, 32'h0};
        vt[9]  = '{1'b0, 6'd5,  1'b0, 6'h09, 32'h0,        4'h0,    32'hAA345678};
        vt[10] = '{1'b1, 6'd0,  1'b1, 6'h3C, 32'hCAFEF00D, 4'hF,    32'h0};
        vt[11] = '{1'b0, 6'd0,  1'b1, 6'h3C, 32'h0,        4'h0,    32'hCAFEF00D};
        vt[12] = '{1'b0, 6'd0,  1'b0, 6'h3C, 32'h0,        4'h0,    32'h0};

        a_req_valid = 0; a_req_we = 0; a_req_index = 0; a_req_way = 0; a_req_offset = 0;
        a_req_wdata = 0; a_req_be = 0; a_refill_start = 0; a_refill_index = 0; a_refill_way = 0;
        a_l2_valid = 0; a_l2_data = 0;
        b_req_valid = 0; b_req_we = 0; b_req_index = 0; b_req_way = 0; b_req_offset = 0;
        b_req_wdata = 0; b_req_be = 0; b_refill_start = 0; b_refill_index = 0; b_refill_way = 0;
        b_l2_valid = 0; b_l2_data = 0;

        tick; tick;
        chk("rst_rdata", 512'(a_rdata), 512'(0));
        chk("rst_line", a_line, 512'(0));
        chk("rst_rvalid", 512'(a_rvalid), 512'(0));
        chk("rst_done", 512'(a_done), 512'(0));
        chk("rst_stall_a", 512'(a_stall), 512'(1));
        chk("rst_stall_b", 512'(b_stall), 512'(1));
        nrst = 1'b1;
        init_wait("boot");

        a_req(1'b0, 6'd63, 1'b1, 6'h3C, 32'h0, 4'h0);
        tick;
        a_req_valid = 1'b0;
        chk("boot_rd_rvalid", 512'(a_rvalid), 512'(1));
        chk("boot_rd_rdata", 512'(a_rdata), 512'(0));
        chk("boot_rd_line", a_line, 512'(0));

        for (int i = 0; i < 13; i++) begin
            a_req(vt[i].we, vt[i].idx, vt[i].way, vt[i].off, vt[i].wd, vt[i].be);
            tick;
            chk($sformatf("vec%0d_rvalid", i), 512'(a_rvalid), 512'(!vt[i].we));
            if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), 512'(a_rdata), 512'(vt[i].exp));
        end
        a_req_valid = 1'b0;

        el = '0;
        el[64 +: 32] = 32'hAA345678;
        a_read_line("set5", 6'd5, 1'b0, 6'h08, el);
        tick;
        chk("hold_rvalid", 512'(a_rvalid), 512'(0));
        chk("hold_rdata", 512'(a_rdata), 512'(32'hAA345678));

        // Refill of set 10 way 1 with same-cycle read of old data and 2-cycle beat gaps.
        a_req(1'b1, 6'd10, 1'b1, 6'h30, 32'h55555555, 4'hF);
        tick;
        a_req(1'b0, 6'd10, 1'b1, 6'h30, 32'h0, 4'h0);
        a_refill_start = 1'b1; a_refill_index = 6'd10; a_refill_way = 1'b1;
        tick;
        a_refill_start = 1'b0; a_req_valid = 1'b0;
        chk("rs_same_rvalid", 512'(a_rvalid), 512'(1));
        chk("rs_same_rdata", 512'(a_rdata), 512'(32'h55555555));
        chk("rs_stall", 512'(a_stall), 512'(1));
        a_req(1'b1, 6'd10, 1'b1, 6'h30, 32'hFFFFFFFF, 4'hF);
        tick;
        a_req_valid = 1'b0;
        chk("rd_in_refill_rvalid", 512'(a_rvalid), 512'(0));
        a_refill_start = 1'b1; a_refill_index = 6'd11; a_refill_way = 1'b0;
        tick;
        a_refill_start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin tick; tick; end
            bv = 8'(8'h11 * (b + 1));
            a_l2_valid = 1'b1; a_l2_data = {16{bv}};
            tick;
            a_l2_valid = 1'b0;
            chk($sformatf("beat%0d_done", b), 512'(a_done), 512'(b == 3));
            chk($sformatf("beat%0d_stall", b), 512'(a_stall), 512'(b != 3));
        end
        tick;
        chk("done_once", 512'(a_done), 512'(0));
        el = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
        a_read_line("refilled", 6'd10, 1'b1, 6'h30, el);
        chk("refilled_rdata", 512'(a_rdata), 512'(32'h44444444));
        a_read_line("ignored_start", 6'd11, 1'b0, 6'h00, 512'(0));

        // Reset in the middle of a refill.
        a_req(1'b1, 6'd20, 1'b0, 6'h00, 32'h600DF00D, 4'hF);
        tick;
        a_req(1'b0, 6'd20, 1'b0, 6'h00, 32'h0, 4'h0);
        tick;
        a_req_valid = 1'b0;
        chk("pre_rst_rdata", 512'(a_rdata), 512'(32'h600DF00D));
        a_refill_start = 1'b1; a_refill_index = 6'd12; a_refill_way = 1'b0;
        tick;
        a_refill_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            a_l2_valid = 1'b1; a_l2_data = {4{32'hA5A5A5A5}};
            tick;
        end
        a_l2_valid = 1'b0;
        nrst = 1'b0;
        #1;
        chk("mid_rst_rdata", 512'(a_rdata), 512'(0));
        chk("mid_rst_line", a_line, 512'(0));
        chk("mid_rst_rvalid", 512'(a_rvalid), 512'(0));
        chk("mid_rst_stall", 512'(a_stall), 512'(1));
        tick; tick;
        nrst = 1'b1;
        init_wait("rerun");
        a_read_line("zero_s20", 6'd20, 1'b0, 6'h00, 512'(0));
        a_read_line("zero_s12", 6'd12, 1'b0, 6'h00, 512'(0));
        a_read_line("zero_s10", 6'd10, 1'b1, 6'h30, 512'(0));
        a_read_line("zero_s5", 6'd5, 1'b0, 6'h08, 512'(0));

        // Single-beat geometry: refill completes two edges after refill_start.
        b_refill_start = 1'b1; b_refill_index = 4'd3; b_refill_way = 1'b0;
        tick;
        b_refill_start = 1'b0;
        chk("b_start_stall", 512'(b_stall), 512'(1));
        for (int w = 0; w < 8; w++) b_l2_data[w*32 +: 32] = 32'hA0000000 + 32'(w);
        b_l2_valid = 1'b1;
        tick;
        b_l2_valid = 1'b0;
        chk("b_done", 512'(b_done), 512'(1));
        chk("b_stall_fall", 512'(b_stall), 512'(0));
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_index = 4'd3; b_req_offset = 5'h1C;
        tick;
        chk("b_rd_rvalid", 512'(b_rvalid), 512'(1));
        chk("b_rd_rdata", 512'(b_rdata), 512'(32'hA0000007));
        b_req_index = 4'd15;
        tick;
        b_req_valid = 1'b0;
        chk("b_rd15_line", 512'(b_line), 512'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
